bram_stream_reader: RTL
=======================

# bram_stream_reader

Read-side controller for the 16×16 block RAM port (4-bit address, 16-bit data, synchronous read). On a start command it reads a contiguous, wrapping address range from the BRAM and delivers the words in order on a valid/ready output stream with full backpressure support. It drives the BRAM port as the initiator, with write enable held low, and sits between the BRAM instance and any downstream stream consumer.

## Interface
- ADDR_W, 4, BRAM address width (depth 2^ADDR_W = 16)
- DATA_W, 16, BRAM/stream data width
- RD_LATENCY, 1, BRAM read latency in cycles from address to dout (legal: 1 or 2)

- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled on every clk edge
- start_addr  in  ADDR_W  first address to read
- len  in  ADDR_W+1  word count, 1..16
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when the last beat has been accepted
- bram_en  out  1  read strobe, high only on cycles that issue a read
- bram_we  out  1  constant 0
- bram_addr  out  ADDR_W  registered read address
- bram_dout  in  DATA_W  BRAM read data
- m_data  out  DATA_W  stream data
- m_valid  out  1  stream data valid
- m_ready  in  1  consumer ready
- m_last  out  1  high with the final beat of a transfer

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: start=1 with len in 1..16 is accepted. It latches the address counter from start_addr and both the issue and beat counters from len, then moves to ISSUE.
  - start while busy is ignored.
  - start with len=0 is ignored: no busy, no done.
- ISSUE: a read is issued (bram_en=1, bram_addr=current address) only when fifo_count + in_flight < 4.
  - The address increments mod 16 after each issue. start_addr=14 with len=4 reads 14, 15, 0, 1.
  - When the final read has been issued, move to DRAIN.
- Read data is written into a 4-entry output FIFO exactly RD_LATENCY cycles after its issue, tracked by an RD_LATENCY-deep valid shift pipe.
  - The credit rule guarantees the FIFO never overflows. No data is dropped under any m_ready pattern.
- m_valid = FIFO not empty. m_data = FIFO head. A beat transfers on m_valid & m_ready.
- m_last = m_valid & (remaining beats == 1).
- m_data and m_last hold stable while m_valid=1 and m_ready=0.
- DRAIN: on the handshake of the last beat, go to IDLE, pulse done, and drop busy.
- bram_addr holds its last value when not issuing.
- Reset (any time, including mid-transfer): state=IDLE, FIFO, pipe and counters cleared. In-flight BRAM data is discarded.
- Reset values: busy=0, done=0, bram_en=0, bram_we=0, bram_addr=0, m_valid=0, m_last=0, m_data=0.

## Timing
- Cycle 0 is the edge where start is accepted.
- Cycle 1: busy=1, first read issued (bram_en=1, bram_addr=start_addr).
- First m_valid is in cycle 2+RD_LATENCY: cycle 3 for RD_LATENCY=1, cycle 4 for RD_LATENCY=2.
- With m_ready held high, throughput is 1 beat/cycle with no bubbles.
  - len=N, RD_LATENCY=1: beats in cycles 3..N+2.
  - done=1 and busy=0 in cycle N+3.
- A new start is accepted in the same cycle done is high.
- With m_ready low, issue stalls once 4 words are buffered or in flight. Issue resumes the cycle after a credit frees.
- done is exactly one cycle wide and is never asserted for an ignored start.

## Test plan
- Single read: preload addr 5=16'hBEEF; start, start_addr=5, len=1, m_ready=1.
  - Expect one beat BEEF with m_last=1 in cycle 3.
  - Expect done in cycle 4 and bram_en high only in cycle 1.
- Full wrap: preload mem[i]=16'h1000+i; start_addr=12, len=16.
  - Expect data 100C..100F, then 1000..100B, back-to-back.
  - Expect m_last on 100B and done in cycle 19.
- Backpressure: len=8, m_ready toggling 1,0,0,1,0 repeating.
  - Expect all 8 words in order, no loss or duplication, data stable during stalls.
  - Expect bram_en never to exceed 4 outstanding.
- Ignored commands: len=0 produces no busy and no done. A start asserted mid-transfer does not alter the address sequence or the count.
- Reset mid-op: assert rst_n=0 in cycle 5 of a len=16 transfer.
  - Expect all outputs at reset values immediately.
  - After release, a fresh len=2 transfer returns exactly 2 correct words.
- RD_LATENCY=2 build: repeat the full-wrap test. Expect first m_valid in cycle 4, done in cycle 20, identical data order.

Source files
------------

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads a wrapping range of a synchronous-read BRAM and
// streams the words out on a valid/ready interface. A small credit-limited
// FIFO absorbs read data so that backpressure never loses a word.
module bram_stream_reader #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int FIFO_D = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [ADDR_W:0]     issue_cnt_reg, issue_cnt_next;
  logic [ADDR_W:0]     beat_cnt_reg, beat_cnt_next;
  logic                bram_en_reg, bram_en_next;
  logic [ADDR_W-1:0]   bram_addr_reg, bram_addr_next;
  logic                done_reg, done_next;
  logic [RD_LATENCY-1:0] pipe_reg;

  logic [DATA_W-1:0]   fifo_mem [FIFO_D];
  logic [1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [2:0]          fifo_cnt_reg;

  logic                fifo_wr, fifo_rd;
  logic [3:0]          pending;
  logic                credit_ok;

  // Words are captured exactly when the latency pipe says the BRAM output is valid.
  assign fifo_wr = pipe_reg[RD_LATENCY-1];
  assign m_valid = (fifo_cnt_reg != 3'd0);
  assign fifo_rd = m_valid & m_ready;
  assign m_data  = fifo_mem[rd_ptr_reg];
  assign m_last  = m_valid & (beat_cnt_reg == (ADDR_W+1)'(1));

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign bram_en   = bram_en_reg;
  assign bram_we   = 1'b0;
  assign bram_addr = bram_addr_reg;

  // Count every word that owns a FIFO slot: buffered, in the pipe, or being read now.
  always_comb begin
    pending = {1'b0, fifo_cnt_reg} + {3'b000, bram_en_reg};
    for (int i = 0; i < RD_LATENCY; i++) begin
      pending = pending + {3'b000, pipe_reg[i]};
    end
    credit_ok = ((pending - {3'b000, fifo_rd}) < 4'(FIFO_D));
  end

  // Next-state logic: command acceptance, credit-gated read issue, completion.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    issue_cnt_next = issue_cnt_reg;
    beat_cnt_next  = beat_cnt_reg;
    bram_en_next   = 1'b0;
    bram_addr_next = bram_addr_reg;
    done_next      = 1'b0;

    if (fifo_rd) begin
      beat_cnt_next = beat_cnt_reg - 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (start && (len != '0) && (len <= (ADDR_W+1)'(DEPTH))) begin
          bram_en_next   = 1'b1;
          bram_addr_next = start_addr;
          addr_next      = start_addr + 1'b1;
          issue_cnt_next = len - 1'b1;
          beat_cnt_next  = len;
          state_next     = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_cnt_reg == '0) begin
          state_next = DRAIN;
        end else if (credit_ok) begin
          bram_en_next   = 1'b1;
          bram_addr_next = addr_reg;
          addr_next      = addr_reg + 1'b1;
          issue_cnt_next = issue_cnt_reg - 1'b1;
          if (issue_cnt_reg == (ADDR_W+1)'(1)) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (fifo_rd && (beat_cnt_reg == (ADDR_W+1)'(1))) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state register; reset aborts any transfer in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      issue_cnt_reg <= '0;
      beat_cnt_reg  <= '0;
      bram_en_reg   <= 1'b0;
      bram_addr_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      issue_cnt_reg <= issue_cnt_next;
      beat_cnt_reg  <= beat_cnt_next;
      bram_en_reg   <= bram_en_next;
      bram_addr_reg <= bram_addr_next;
      done_reg      <= done_next;
    end
  end

  // Latency pipe: one bit per stage marks a read whose data is still in the BRAM.
  generate
    for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_first
        // First stage follows the read strobe.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) pipe_reg[0] <= 1'b0;
          else        pipe_reg[0] <= bram_en_reg;
        end
      end else begin : g_rest
        // Later stages shift the marker along.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) pipe_reg[gi] <= 1'b0;
          else        pipe_reg[gi] <= pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  // FIFO pointers and occupancy; simultaneous write and read keep the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (fifo_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (fifo_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (fifo_wr && !fifo_rd)      fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
      else if (!fifo_wr && fifo_rd) fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
    end
  end

  // FIFO storage, cleared on reset so the idle stream data reads as zero.
  generate
    for (genvar gi = 0; gi < FIFO_D; gi++) begin : g_fifo
      // One entry: written when the write pointer selects it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             fifo_mem[gi] <= '0;
        else if (fifo_wr && (wr_ptr_reg == gi)) fifo_mem[gi] <= bram_dout;
      end
    end
  endgenerate

endmodule
